// File: rtl/mux_2x1_pkg.sv
// Shared width constants for the datapath 2:1 word multiplexers.
package mux_2x1_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned WIDTH_MAX  = 64;

endpackage : mux_2x1_pkg

// File: rtl/mux_2x1_reg.sv
// WIDTH-bit pipeline register with synchronous active-low clear.
module mux_2x1_reg
    import mux_2x1_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule : mux_2x1_reg

// File: rtl/mux_2x1.sv
// Parameterised 2:1 word mux with optional registered copy of the output.
// Build option: define MUX2X1_REG_OUT_EN to include the pipeline register.
module mux_2x1
    import mux_2x1_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] input0,
    input  logic [WIDTH-1:0] input1,
    input  logic             SEL,
    output logic [WIDTH-1:0] mux_out,
    output logic [WIDTH-1:0] mux_out_q,
    output logic             sel_unknown
);

    // An unknown select poisons every output bit rather than merging the inputs.
    always_comb begin
        mux_out     = input0;
        sel_unknown = 1'b0;
        if (SEL == 1'b1) begin
            mux_out = input1;
        end else if (SEL == 1'b0) begin
            mux_out = input0;
        end
`ifndef SYNTHESIS
        else begin
            mux_out     = {WIDTH{1'bx}};
            sel_unknown = 1'b1;
        end
`endif
    end

`ifdef MUX2X1_REG_OUT_EN
    mux_2x1_reg #(
        .WIDTH (WIDTH)
    ) u_out_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (mux_out),
        .q     (mux_out_q)
    );
`else
    // Register path not built: clock and reset are intentionally dangling.
    logic unused_clk_rst;
    assign unused_clk_rst = &{1'b0, clk, rst_n};
    assign mux_out_q      = '0;
`endif

endmodule : mux_2x1

// File: tb/tb_mux_2x1.sv
// Randomised self-checking bench for mux_2x1 at widths 32 and 5.
module tb_mux_2x1;
    import mux_2x1_pkg::*;

`ifdef MUX2X1_REG_OUT_EN
    localparam bit REG_EN = 1'b1;
`else
    localparam bit REG_EN = 1'b0;
`endif

    logic                  clk;
    logic                  rst_n;
    logic                  SEL;
    logic [DATA_W-1:0]     in0, in1;
    logic [REG_ADDR_W-1:0] a0, a1;
    logic [DATA_W-1:0]     out32, out32_q;
    logic [REG_ADDR_W-1:0] out5, out5_q;
    logic                  unk32, unk5;

    int errors = 0;
    int checks = 0;

    mux_2x1 #(.WIDTH(DATA_W)) dut32 (
        .clk         (clk),
        .rst_n       (rst_n),
        .input0      (in0),
        .input1      (in1),
        .SEL         (SEL),
        .mux_out     (out32),
        .mux_out_q   (out32_q),
        .sel_unknown (unk32)
    );

    mux_2x1 #(.WIDTH(REG_ADDR_W)) dut5 (
        .clk         (clk),
        .rst_n       (rst_n),
        .input0      (a0),
        .input1      (a1),
        .SEL         (SEL),
        .mux_out     (out5),
        .mux_out_q   (out5_q),
        .sel_unknown (unk5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: pick the word named by a known select.
    function automatic logic [DATA_W-1:0] pick(input logic s, input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
        return s ? b : a;
    endfunction

    // Drive one cycle of stimulus, check the combinational outputs, then the registered ones.
    task automatic apply(input logic r, input logic s, input logic [DATA_W-1:0] a,
                         input logic [DATA_W-1:0] b, input string tag);
        logic [DATA_W-1:0] exp_w;
        logic [DATA_W-1:0] exp_q;
        rst_n = r;
        SEL   = s;
        in0   = a;
        in1   = b;
        a0    = a[REG_ADDR_W-1:0];
        a1    = b[REG_ADDR_W-1:0];
        exp_w = pick(s, a, b);
        exp_q = (REG_EN && r) ? exp_w : '0;
        #1;
        checks++;
        if (out32 !== exp_w) begin
            errors++;
            $display("FAIL %s mux_out32: got %h expected %h", tag, out32, exp_w);
        end
        checks++;
        if (out5 !== exp_w[REG_ADDR_W-1:0]) begin
            errors++;
            $display("FAIL %s mux_out5: got %h expected %h", tag, out5, exp_w[REG_ADDR_W-1:0]);
        end
        checks++;
        if (unk32 !== 1'b0 || unk5 !== 1'b0) begin
            errors++;
            $display("FAIL %s sel_unknown: got %b/%b expected 0/0", tag, unk32, unk5);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out32_q !== exp_q) begin
            errors++;
            $display("FAIL %s mux_out_q32: got %h expected %h", tag, out32_q, exp_q);
        end
        checks++;
        if (out5_q !== exp_q[REG_ADDR_W-1:0]) begin
            errors++;
            $display("FAIL %s mux_out_q5: got %h expected %h", tag, out5_q, exp_q[REG_ADDR_W-1:0]);
        end
        checks++;
        if (out32 !== exp_w) begin
            errors++;
            $display("FAIL %s mux_out32_after_edge: got %h expected %h", tag, out32, exp_w);
        end
    endtask

    task automatic test_reset();
        apply(1'b0, 1'b1, 32'h0000_0001, 32'h0000_FFFF, "reset_edge1");
        apply(1'b0, 1'b0, 32'hDEAD_BEEF, 32'h1234_5678, "reset_edge2");
    endtask

    task automatic test_directed();
        apply(1'b1, 1'b0, 32'h0000_0001, 32'h0000_001F, "w5_sel0");
        apply(1'b1, 1'b1, 32'h0000_0001, 32'h0000_001F, "w5_sel1");
        apply(1'b1, 1'b0, 32'h0000_0001, 32'h0000_FFFF, "w32_sel0");
        apply(1'b1, 1'b1, 32'h0000_0001, 32'h0000_FFFF, "w32_sel1");
        apply(1'b1, 1'b1, 32'h0000_0000, 32'hFFFF_FFFF, "all_ones");
        apply(1'b1, 1'b0, 32'h8000_0000, 32'h0000_0000, "msb_only");
    endtask

    task automatic test_midstream_reset();
        apply(1'b1, 1'b1, 32'h0000_0001, 32'h0000_FFFF, "mid_pre");
        apply(1'b0, 1'b1, 32'h0000_0001, 32'h0000_FFFF, "mid_clear");
        apply(1'b1, 1'b1, 32'h0000_0001, 32'h0000_FFFF, "mid_release");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            apply(($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
                  32'($urandom), 32'($urandom), "random");
        end
    endtask

    // Unknown select is only observable on a four-state simulator.
    task automatic test_x_select();
        logic probe;
        logic [DATA_W-1:0] all_x32;
        logic [REG_ADDR_W-1:0] all_x5;
        probe   = 1'bx;
        all_x32 = {DATA_W{1'bx}};
        all_x5  = {REG_ADDR_W{1'bx}};
        if ($isunknown(probe)) begin
            rst_n = 1'b1;
            in0   = 32'h0000_0001;
            in1   = 32'h0000_FFFF;
            a0    = 5'b00001;
            a1    = 5'b11111;
            SEL   = 1'bx;
            #1;
            checks++;
            if (out32 !== all_x32 || out5 !== all_x5) begin
                errors++;
                $display("FAIL x_sel mux_out: got %h/%b expected all X", out32, out5);
            end
            checks++;
            if (unk32 !== 1'b1 || unk5 !== 1'b1) begin
                errors++;
                $display("FAIL x_sel sel_unknown: got %b/%b expected 1/1", unk32, unk5);
            end
            @(posedge clk);
            #1;
            checks++;
            if (out32_q !== (REG_EN ? all_x32 : '0)) begin
                errors++;
                $display("FAIL x_sel mux_out_q32: got %h expected %s", out32_q,
                         REG_EN ? "all X" : "zero");
            end
            apply(1'b1, 1'b0, 32'h0000_0001, 32'h0000_FFFF, "x_recover");
        end
    endtask

    initial begin
        rst_n = 1'b0;
        SEL   = 1'b0;
        in0   = '0;
        in1   = '0;
        a0    = '0;
        a1    = '0;
        @(negedge clk);
        test_reset();
        test_directed();
        test_midstream_reset();
        test_x_select();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mux_2x1
